// File: rtl/segments_pkg.sv
// Shared 7-segment definitions: digit decode table, display polarity constants, segment bit positions.
// Pure constants and types; no logic, no latency, no flow control.
package segments_pkg;

  localparam logic COMMON_CATHODE_CONTROL = 1'b0;
  localparam logic COMMON_ANODE_CONTROL   = 1'b1;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Logical {a..g,dp} patterns, entry 9 leftmost so DECODE_TABLE[n] is digit n.
  localparam logic [9:0][7:0] DECODE_TABLE = {
    8'b11110110, 8'b11111110, 8'b11100000, 8'b10111110, 8'b10110110,
    8'b01100110, 8'b11110010, 8'b11011010, 8'b01100000, 8'b11111100
  };

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/segments_digit_decode.sv
// Nibble -> logical segment pattern (dp bit clear) plus overflow flag for nibbles 10..15.
// Purely combinational, zero latency, no backpressure.
module segments_digit_decode
  import segments_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern,
  output logic       overflow
);

  logic [3:0] digit;

  // Out-of-range nibbles wrap onto 0..5 and raise the overflow flag.
  always_comb begin
    overflow = (nibble >= 4'd10);
    digit    = overflow ? (nibble - 4'd10) : nibble;
    pattern  = DECODE_TABLE[digit];
  end

endmodule

// File: rtl/segments_scan_driver.sv
// Multiplexed DIGITS_V-digit 7-segment scanner; outputs registered, new digit shown the cycle after each prescaler tick.
// One-word valid/ready buffer: data_ready drops on accept until the next frame boundary. Optional SEGMENTS_LEADING_ZERO_BLANK_EN.
module segments_scan_driver
  import segments_pkg::*;
#(
  parameter int   DIGITS_V       = 4,
  parameter int   CLK_DIV_V      = 1000,
  parameter logic CONTROL_TYPE_V = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*DIGITS_V-1:0]   data_bus,
  input  logic [DIGITS_V-1:0]     dp_bus,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [7:0]              segment_value_bus,
  output logic [DIGITS_V-1:0]     digit_select_bus,
  output logic [DIGITS_V-1:0]     overflow_bus,
  output logic                    frame_start
);

  localparam int IDX_W     = (DIGITS_V > 1) ? $clog2(DIGITS_V) : 1;
  localparam int NUM_SLOTS = 1 << IDX_W;
  localparam int CNT_W     = $clog2(CLK_DIV_V);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DIGITS_V - 1);
  localparam logic [CNT_W-1:0]    TERM_CNT = CNT_W'(CLK_DIV_V - 1);
  localparam logic                ANODE    = (CONTROL_TYPE_V == COMMON_ANODE_CONTROL);
  localparam logic [7:0]          SEG_OFF  = ANODE ? 8'hFF : 8'h00;
  localparam logic [DIGITS_V-1:0] SEL_OFF  = ANODE ? {DIGITS_V{1'b0}} : {DIGITS_V{1'b1}};

  scan_state_t             state, state_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [4*DIGITS_V-1:0]   pending, pending_d, shadow, shadow_d;
  logic [DIGITS_V-1:0]     pending_dp, pending_dp_d, shadow_dp, shadow_dp_d;
  logic                    ready_d;
  logic                    tick, boundary, accept;

  logic [DIGITS_V-1:0]     blank, digit_ovf;
  logic                    blank_run;
  logic [7:0]              slot_pat [NUM_SLOTS];
  logic [7:0]              seg_logic, seg_d;
  logic [DIGITS_V-1:0]     sel_onehot, sel_d, ovf_d;
  logic                    fs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN_IDLE;
      idx        <= '0;
      cnt        <= '0;
      pending    <= '0;
      pending_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      data_ready <= 1'b1;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      pending    <= pending_d;
      pending_dp <= pending_dp_d;
      shadow     <= shadow_d;
      shadow_dp  <= shadow_dp_d;
      data_ready <= ready_d;
    end
  end

  // The first tick after reset lights digit 0 instead of advancing, so scanning starts on a frame.
  always_comb begin
    tick     = (cnt == TERM_CNT);
    boundary = tick && (idx == LAST_IDX);
    accept   = data_valid && data_ready;
    cnt_d    = tick ? '0 : cnt + 1'b1;
    state_d  = state;
    idx_d    = idx;
    if (tick) begin
      if (state == SCAN_IDLE) state_d = SCAN_RUN;
      else                    idx_d   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    pending_d    = pending;
    pending_dp_d = pending_dp;
    shadow_d     = shadow;
    shadow_dp_d  = shadow_dp;
    ready_d      = data_ready;
    if (accept && boundary) begin
      shadow_d    = data_bus;
      shadow_dp_d = dp_bus;
    end else if (accept) begin
      pending_d    = data_bus;
      pending_dp_d = dp_bus;
      ready_d      = 1'b0;
    end else if (boundary && !data_ready) begin
      shadow_d    = pending;
      shadow_dp_d = pending_dp;
      ready_d     = 1'b1;
    end
  end

`ifdef SEGMENTS_LEADING_ZERO_BLANK_EN
  // Blanking runs from the top digit down and stops at the first nonzero nibble or lit dp.
  always_comb begin
    blank     = '0;
    blank_run = 1'b1;
    for (int n = DIGITS_V - 1; n >= 1; n--) begin
      blank_run = blank_run && (shadow_d[4*n +: 4] == 4'd0) && !shadow_dp_d[n];
      blank[n]  = blank_run;
    end
  end
`else
  assign blank     = '0;
  assign blank_run = 1'b0;
`endif

  for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_slot
    if (n < DIGITS_V) begin : g_digit
      logic [7:0] digit_pat;
      segments_digit_decode u_decode (
        .nibble   (shadow_d[4*n +: 4]),
        .pattern  (digit_pat),
        .overflow (digit_ovf[n])
      );
      assign slot_pat[n] = blank[n] ? 8'h00 : (digit_pat | {7'b0, shadow_dp_d[n]});
    end else begin : g_pad
      assign slot_pat[n] = 8'h00;
    end
  end

  // Outputs are computed from next-state values so the register shows the new digit right after a tick.
  always_comb begin
    seg_logic  = 8'h00;
    sel_onehot = '0;
    if (state_d == SCAN_RUN) begin
      seg_logic  = slot_pat[idx_d];
      sel_onehot = DIGITS_V'(1) << idx_d;
    end
    seg_d = ANODE ? ~seg_logic : seg_logic;
    sel_d = ANODE ? sel_onehot : ~sel_onehot;
    ovf_d = digit_ovf & ~blank;
    fs_d  = tick && (idx_d == '0) && !blank_run;
    fs_d  = tick && (idx_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segment_value_bus <= SEG_OFF;
      digit_select_bus  <= SEL_OFF;
      overflow_bus      <= '0;
      frame_start       <= 1'b0;
    end else begin
      segment_value_bus <= seg_d;
      digit_select_bus  <= sel_d;
      overflow_bus      <= ovf_d;
      frame_start       <= fs_d;
    end
  end

endmodule
